mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_req, input, 1, instruction-fetch request; held with i_addr until i_gnt.
REQ-006 SHALL have port i_addr, input, ADDR_W, fetch address.
REQ-007 SHALL have port i_gnt, output, 1, one-cycle grant pulse to the fetch port.
REQ-008 SHALL have port i_rvalid, output, 1, one-cycle fetch-data-valid pulse.
REQ-009 SHALL have port i_rdata, output, DATA_W, fetched word.
REQ-010 SHALL have port d_req, input, 1, data request; held with d_addr/d_we/d_wdata until d_gnt.
REQ-011 SHALL have port d_addr, input, ADDR_W, data address.
REQ-012 SHALL have port d_we, input, 4, byte write enables; 0 means read.
REQ-013 SHALL have port d_wdata, input, DATA_W, store data.
REQ-014 SHALL have ports d_gnt (output, 1, grant pulse), d_rvalid (output, 1, completion pulse for read or write) and d_rdata (output, DATA_W, load data).
REQ-015 SHALL have memory-side outputs mem_addr (ADDR_W), mem_re (1), mem_we (4) and mem_wdata (DATA_W), and input mem_rdata (DATA_W), valid the cycle after mem_re was sampled.

Function
REQ-016 SHALL implement FSM states IDLE, ACC and RESP: IDLE->ACC on any request, ACC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-017 SHALL, in IDLE with exactly one request, grant that requester.
REQ-018 SHALL, in IDLE with both requests, grant the requester not served last (last_d flag); last_d resets to 1, so fetch wins the first tie.
REQ-019 SHALL, on the IDLE->ACC edge, register the winner's request onto the memory outputs:
- mem_addr <= winner address
- mem_we <= d_we for data, 0 for fetch
- mem_wdata <= d_wdata
- mem_re <= (mem_we == 0)
- the winner's gnt <= 1
- last_d updated
REQ-020 SHALL, on the ACC->RESP edge, clear mem_re, mem_we and both gnt outputs; mem_addr and mem_wdata hold.
REQ-021 SHALL, on the RESP->IDLE edge, latch mem_rdata into the owner's rdata for reads, leave d_rdata unchanged for writes, and pulse the owner's rvalid for exactly one cycle.
REQ-022 SHALL give fixed latency: request sampled at edge E1 -> gnt high E1..E2 -> rvalid high E3..E4; throughput one access per 3 cycles.
REQ-023 SHALL ignore requests outside IDLE; a req still high in the IDLE cycle after rvalid is a new request.
REQ-024 SHALL never assert i_gnt and d_gnt together, nor i_rvalid and d_rvalid together.
REQ-025 SHALL not check alignment or address range; mem_addr is passed through as-is.
REQ-026 SHALL track the current owner in a registered 1-bit field that is valid in ACC and RESP.

Reset
REQ-027 SHALL, on rst asserted at any time, asynchronously force:
- state IDLE
- last_d 1
- all gnt, rvalid, mem_re and mem_we 0
- all addr/data outputs 0
REQ-028 SHALL drop any in-flight access when reset hits mid-ACC or mid-RESP, with no rvalid issued afterwards.

Structure
REQ-029 SHALL place the state encoding (IDLE=0, ACC=1, RESP=2), owner encoding (OWN_I=0, OWN_D=1) and WE_NONE=4'h0 / WE_WORD=4'hf constants in shared package mem_arb_pkg.
REQ-030 SHALL implement tie-breaking in sub-module mem_arb_rr: inputs req_i, req_d, last_d; outputs gnt_i and gnt_d, combinational one-hot or zero.

Verification
REQ-031 SHALL cover a single fetch: i_req=1, i_addr=0x10, memory returns 0x00A00093 -> i_gnt one cycle, mem_re=1, mem_addr=0x10, i_rvalid 2 cycles after i_gnt, i_rdata=0x00A00093.
REQ-032 SHALL cover a store word: d_req=1, d_addr=0x2000, d_we=4'hf, d_wdata=0xDEADBEEF -> mem_we=4'hf for exactly one cycle, mem_re=0, d_rvalid pulse, d_rdata unchanged.
REQ-033 SHALL cover a tie after reset: both requests held continuously -> grant order I,D,I,D with gnts 3 cycles apart and never overlapping.
REQ-034 SHALL cover a data-only stream: d_req held 9 cycles, i_req=0 -> 3 consecutive data grants, no fetch grant.
REQ-035 SHALL cover reset in RESP: rst pulsed during RESP of a fetch -> no i_rvalid, all outputs 0, next i_req is served normally.
REQ-036 SHALL cover a late request: i_req raised during ACC of a data access -> i_req ignored until IDLE, then i_gnt in the cycle after d_rvalid's IDLE cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared encodings for the two-port memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic       OWN_I   = 1'b0;
    localparam logic       OWN_D   = 1'b1;
    localparam logic [3:0] WE_NONE = 4'h0;
    localparam logic [3:0] WE_WORD = 4'hf;

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_rr
// Purpose  : Two-way round-robin tie-break; grants are one-hot or zero.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_rr (
    input  logic req_i,
    input  logic req_d,
    input  logic last_d,
    output logic gnt_i,
    output logic gnt_d
);

    // On a tie the side that was not served last wins.
    assign gnt_i = req_i & (~req_d | last_d);
    assign gnt_d = req_d & (~req_i | ~last_d);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Fixed-latency arbiter sharing one memory port between fetch and data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic [3:0]        mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t r_state;
    logic   r_last_d;
    logic   r_owner;
    logic   r_rd;
    logic   w_gnt_i;
    logic   w_gnt_d;
    logic   w_req_i;
    logic   w_req_d;
    logic [3:0] w_we;

    // Requests only count while idle; the tie-break sees nothing otherwise.
    assign w_req_i = i_req & (r_state == IDLE);
    assign w_req_d = d_req & (r_state == IDLE);
    assign w_we    = w_gnt_d ? d_we : WE_NONE;

    mem_arb_rr u_rr (
        .req_i  (w_req_i),
        .req_d  (w_req_d),
        .last_d (r_last_d),
        .gnt_i  (w_gnt_i),
        .gnt_d  (w_gnt_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b1;
            r_owner   <= OWN_I;
            r_rd      <= 1'b0;
            i_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= WE_NONE;
            mem_wdata <= '0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_i || w_gnt_d) begin
                        r_state   <= ACC;
                        r_owner   <= w_gnt_d ? OWN_D : OWN_I;
                        r_last_d  <= w_gnt_d;
                        r_rd      <= (w_we == WE_NONE);
                        mem_addr  <= w_gnt_d ? d_addr : i_addr;
                        mem_we    <= w_we;
                        mem_wdata <= d_wdata;
                        mem_re    <= (w_we == WE_NONE);
                        i_gnt     <= w_gnt_i;
                        d_gnt     <= w_gnt_d;
                    end
                end
                ACC: begin
                    r_state <= RESP;
                    mem_re  <= 1'b0;
                    mem_we  <= WE_NONE;
                    i_gnt   <= 1'b0;
                    d_gnt   <= 1'b0;
                end
                RESP: begin
                    r_state <= IDLE;
                    if (r_owner == OWN_D) begin
                        d_rvalid <= 1'b1;
                        if (r_rd) begin
                            d_rdata <= mem_rdata;
                        end
                    end else begin
                        i_rvalid <= 1'b1;
                        i_rdata  <= mem_rdata;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
